// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN receive field controller:
//   - field_e     : field/state codes, also driven on the controller's field port
//   - LEN_*       : bit lengths of the multi-bit fields
//   - BASE_*      : frame length excluding IFS and data, standard / extended
//   - data_bit_count() : number of data-field bits implied by RTR and DLC
// ---------------------------------------------------------------------------
package can_pkg;

    typedef enum logic [3:0] {
        F_IDLE    = 4'd0,
        F_ID_A    = 4'd1,
        F_RTR_SRR = 4'd2,
        F_IDE     = 4'd3,
        F_ID_B    = 4'd4,
        F_RTR_EXT = 4'd5,
        F_R1      = 4'd6,
        F_R0      = 4'd7,
        F_DLC     = 4'd8,
        F_DATA    = 4'd9,
        F_CRC     = 4'd10,
        F_CRC_DEL = 4'd11,
        F_ACK     = 4'd12,
        F_ACK_DEL = 4'd13,
        F_EOF     = 4'd14,
        F_IFS     = 4'd15
    } field_e;

    localparam logic [6:0] LEN_ONE  = 7'd1;
    localparam logic [6:0] LEN_ID_A = 7'd11;
    localparam logic [6:0] LEN_ID_B = 7'd18;
    localparam logic [6:0] LEN_DLC  = 7'd4;
    localparam logic [6:0] LEN_CRC  = 7'd15;
    localparam logic [6:0] LEN_EOF  = 7'd7;
    localparam logic [6:0] LEN_IFS  = 7'd3;

    // Frame length from SOF to the end of EOF when the data field is empty.
    localparam logic [7:0] BASE_STD = 8'd44;
    localparam logic [7:0] BASE_EXT = 8'd64;

    // Remote frames carry no data; DLC values above 8 still mean 8 bytes.
    function automatic logic [6:0] data_bit_count(input logic rtr_bit, input logic [3:0] dlc_val);
        logic [3:0] bytes;
        bytes = (dlc_val > 4'd8) ? 4'd8 : dlc_val;
        data_bit_count = rtr_bit ? 7'd0 : {bytes, 3'b000};
    endfunction

endpackage

// File: rtl/can_bit_watchdog.sv
// ---------------------------------------------------------------------------
// can_bit_watchdog
// Counts clocks since the last destuffed bit while a frame is in progress.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : frame in progress; counter held at zero otherwise
//   restart    : a bit arrived this cycle; counter restarts
//   timeout    : single-cycle pulse when LIMIT clocks passed without restart
// ---------------------------------------------------------------------------
module can_bit_watchdog #(
    parameter int LIMIT = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic timeout
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_reg;

    // cnt_reg holds the number of bit-less clocks already seen, so the
    // LIMIT-th such clock is the one where the count reads LIMIT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!enable || restart) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign timeout = enable && !restart && (cnt_reg == LAST);

endmodule

// File: rtl/can_rx_field_ctrl.sv
// ---------------------------------------------------------------------------
// can_rx_field_ctrl
// Tracks the field structure of a received CAN frame from destuffed bits.
//   clk, rst_n          : clock, asynchronous active-low reset
//   din, dvalid         : destuffed bit and its one-cycle strobe
//   sof                 : start of frame, coincides with the SOF bit strobe
//   error, overload     : abort requests
//   sample_en           : high from SOF through the last IFS bit
//   field               : current field code (can_pkg::field_e)
//   frame_bits          : destuffed bits received so far, SOF included
//   frame_length_bits   : total length excluding IFS, valid with length_valid
//   id, ide, rtr, dlc   : captured header fields
//   crc_en              : high from SOF through the last data bit
//   frame_done          : pulse after the 7th EOF bit
//   frame_abort         : pulse after an abort (error, overload or watchdog)
// ---------------------------------------------------------------------------
module can_rx_field_ctrl
    import can_pkg::*;
#(
    parameter int clk_speed_MHz      = 100,
    parameter int can_bit_rate_Kbits = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        dvalid,
    input  logic        sof,
    input  logic        error,
    input  logic        overload,
    output logic        sample_en,
    output logic [3:0]  field,
    output logic [7:0]  frame_bits,
    output logic [7:0]  frame_length_bits,
    output logic        length_valid,
    output logic [28:0] id,
    output logic        ide,
    output logic        rtr,
    output logic [3:0]  dlc,
    output logic        crc_en,
    output logic        frame_done,
    output logic        frame_abort
);
    localparam int BIT_CYCLES = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
    localparam int WD_LIMIT   = (2 * BIT_CYCLES < 2) ? 2 : 2 * BIT_CYCLES;

    field_e      state_reg, state_next;
    logic [6:0]  cnt_reg, cnt_next;
    logic [6:0]  field_len;
    logic [6:0]  n_bits_reg;
    logic [6:0]  n_calc;
    logic        last_bit;
    logic        start;
    logic        abort;
    logic        timeout;

    logic [7:0]  frame_bits_reg;
    logic [7:0]  frame_len_reg;
    logic        length_valid_reg;
    logic        sample_en_reg;
    logic        crc_en_reg;
    logic [28:0] id_reg;
    logic        ide_reg;
    logic        rtr_reg;
    logic [3:0]  dlc_reg;
    logic        frame_done_reg;
    logic        frame_abort_reg;

    can_bit_watchdog #(
        .LIMIT(WD_LIMIT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_reg != F_IDLE),
        .restart(dvalid),
        .timeout(timeout)
    );

    // Abort requests outrank any bit or SOF arriving in the same cycle.
    assign abort = (state_reg != F_IDLE) && (error || overload || timeout);
    assign start = (state_reg == F_IDLE) && sof && !error && !overload;

    // Data length using the DLC value that includes the bit arriving now.
    assign n_calc = data_bit_count(rtr_reg, {dlc_reg[2:0], din});

    always_comb begin
        field_len = LEN_ONE;
        case (state_reg)
            F_ID_A:  field_len = LEN_ID_A;
            F_ID_B:  field_len = LEN_ID_B;
            F_DLC:   field_len = LEN_DLC;
            F_DATA:  field_len = n_bits_reg;
            F_CRC:   field_len = LEN_CRC;
            F_EOF:   field_len = LEN_EOF;
            F_IFS:   field_len = LEN_IFS;
            default: field_len = LEN_ONE;
        endcase
    end

    assign last_bit = dvalid && (cnt_reg == field_len - 7'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= F_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = F_IDLE;
        end else if (start) begin
            state_next = F_ID_A;
        end else if (last_bit) begin
            case (state_reg)
                F_ID_A:    state_next = F_RTR_SRR;
                F_RTR_SRR: state_next = F_IDE;
                F_IDE:     state_next = din ? F_ID_B : F_R0;
                F_ID_B:    state_next = F_RTR_EXT;
                F_RTR_EXT: state_next = F_R1;
                F_R1:      state_next = F_R0;
                F_R0:      state_next = F_DLC;
                F_DLC:     state_next = (n_calc != 7'd0) ? F_DATA : F_CRC;
                F_DATA:    state_next = F_CRC;
                F_CRC:     state_next = F_CRC_DEL;
                F_CRC_DEL: state_next = F_ACK;
                F_ACK:     state_next = F_ACK_DEL;
                F_ACK_DEL: state_next = F_EOF;
                F_EOF:     state_next = F_IFS;
                F_IFS:     state_next = F_IDLE;
                default:   state_next = state_reg;
            endcase
        end
    end

    // The per-field counter restarts on every state change.
    always_comb begin
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (dvalid && (state_reg != F_IDLE)) begin
            cnt_next = cnt_reg + 7'd1;
        end else begin
            cnt_next = cnt_reg;
        end
    end

    // Frame bookkeeping and header capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_bits_reg   <= '0;
            frame_len_reg    <= '0;
            length_valid_reg <= 1'b0;
            sample_en_reg    <= 1'b0;
            crc_en_reg       <= 1'b0;
            id_reg           <= '0;
            ide_reg          <= 1'b0;
            rtr_reg          <= 1'b0;
            dlc_reg          <= '0;
            n_bits_reg       <= '0;
            frame_done_reg   <= 1'b0;
            frame_abort_reg  <= 1'b0;
        end else begin
            frame_done_reg  <= 1'b0;
            frame_abort_reg <= 1'b0;
            if (abort) begin
                frame_abort_reg  <= 1'b1;
                sample_en_reg    <= 1'b0;
                length_valid_reg <= 1'b0;
                crc_en_reg       <= 1'b0;
                frame_bits_reg   <= '0;
            end else if (start) begin
                frame_bits_reg   <= 8'd1;
                sample_en_reg    <= 1'b1;
                crc_en_reg       <= 1'b1;
                length_valid_reg <= 1'b0;
                frame_len_reg    <= '0;
                id_reg           <= '0;
                ide_reg          <= 1'b0;
                rtr_reg          <= 1'b0;
                dlc_reg          <= '0;
                n_bits_reg       <= '0;
            end else if (dvalid && (state_reg != F_IDLE)) begin
                // IFS bits are not part of the frame length.
                if ((state_reg != F_IFS) && (frame_bits_reg != 8'hFF)) begin
                    frame_bits_reg <= frame_bits_reg + 8'd1;
                end
                case (state_reg)
                    F_ID_A:    id_reg[28:18] <= {id_reg[27:18], din};
                    F_RTR_SRR: rtr_reg <= din;  // overwritten by RTR_EXT in extended frames
                    F_IDE:     ide_reg <= din;
                    F_ID_B:    id_reg[17:0] <= {id_reg[16:0], din};
                    F_RTR_EXT: rtr_reg <= din;
                    F_DLC: begin
                        dlc_reg <= {dlc_reg[2:0], din};
                        if (last_bit) begin
                            n_bits_reg       <= n_calc;
                            frame_len_reg    <= (ide_reg ? BASE_EXT : BASE_STD) + {1'b0, n_calc};
                            length_valid_reg <= 1'b1;
                            if (n_calc == 7'd0) begin
                                crc_en_reg <= 1'b0;
                            end
                        end
                    end
                    F_DATA: begin
                        if (last_bit) begin
                            crc_en_reg <= 1'b0;
                        end
                    end
                    F_EOF: begin
                        if (last_bit) begin
                            frame_done_reg <= 1'b1;
                        end
                    end
                    F_IFS: begin
                        if (last_bit) begin
                            sample_en_reg    <= 1'b0;
                            length_valid_reg <= 1'b0;
                            frame_bits_reg   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output decode
    always_comb begin
        field             = state_reg;
        sample_en         = sample_en_reg;
        frame_bits        = frame_bits_reg;
        frame_length_bits = frame_len_reg;
        length_valid      = length_valid_reg;
        id                = id_reg;
        ide               = ide_reg;
        rtr               = rtr_reg;
        dlc               = dlc_reg;
        crc_en            = crc_en_reg;
        frame_done        = frame_done_reg;
        frame_abort       = frame_abort_reg;
    end

endmodule

// File: tb/tb_can_rx_field_ctrl.sv
`timescale 1ns/1ps
module tb_can_rx_field_ctrl;

    localparam int WD_CLOCKS = 200;  // 2 * (100 MHz / 1 Mbit/s)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        dvalid = 1'b0;
    logic        sof = 1'b0;
    logic        error = 1'b0;
    logic        overload = 1'b0;
    logic        sample_en;
    logic [3:0]  field;
    logic [7:0]  frame_bits;
    logic [7:0]  frame_length_bits;
    logic        length_valid;
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic        crc_en;
    logic        frame_done;
    logic        frame_abort;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    can_rx_field_ctrl #(
        .clk_speed_MHz     (100),
        .can_bit_rate_Kbits(1000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .din              (din),
        .dvalid           (dvalid),
        .sof              (sof),
        .error            (error),
        .overload         (overload),
        .sample_en        (sample_en),
        .field            (field),
        .frame_bits       (frame_bits),
        .frame_length_bits(frame_length_bits),
        .length_valid     (length_valid),
        .id               (id),
        .ide              (ide),
        .rtr              (rtr),
        .dlc              (dlc),
        .crc_en           (crc_en),
        .frame_done       (frame_done),
        .frame_abort      (frame_abort)
    );

    // ---------------- frame plan: per-bit value and the field it belongs to
    int          plan_field[$];
    logic        plan_bits[$];
    int          plan_total = 0, plan_flen = 0, plan_dlc_end = 0, plan_crc_start = 0;
    logic [28:0] plan_id = '0;
    logic        plan_ide = 1'b0, plan_rtr = 1'b0;
    logic [3:0]  plan_dlc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_seg(input int f, input int n, input logic [63:0] val);
        for (int i = n - 1; i >= 0; i--) begin
            plan_field.push_back(f);
            plan_bits.push_back(val[i]);
        end
    endtask

    task automatic build_plan(input logic ext, input logic r, input logic [28:0] ident, input logic [3:0] d);
        int nd;
        plan_field.delete();
        plan_bits.delete();
        nd = r ? 0 : 8 * ((d > 4'd8) ? 8 : int'(d));
        add_seg(0, 1, 64'(0));                    // SOF, consumed while idle
        add_seg(1, 11, 64'(ident[28:18]));
        add_seg(2, 1, 64'(ext ? 1'b1 : r));       // SRR is recessive in extended frames
        add_seg(3, 1, 64'(ext));
        if (ext) begin
            add_seg(4, 18, 64'(ident[17:0]));
            add_seg(5, 1, 64'(r));
            add_seg(6, 1, 64'(0));
        end
        add_seg(7, 1, 64'(0));
        add_seg(8, 4, 64'(d));
        plan_dlc_end = plan_field.size() - 1;
        if (nd > 0) add_seg(9, nd, {$urandom, $urandom});
        plan_crc_start = plan_field.size();
        add_seg(10, 15, 64'($urandom));
        add_seg(11, 1, 64'(1));
        add_seg(12, 1, 64'(0));
        add_seg(13, 1, 64'(1));
        add_seg(14, 7, 64'(7'h7F));
        plan_flen = plan_field.size();
        add_seg(15, 3, 64'(3'h7));
        plan_total = plan_field.size();
        plan_id  = ext ? ident : {ident[28:18], 18'd0};
        plan_ide = ext;
        plan_rtr = r;
        plan_dlc = d;
    endtask

    // ---------------- behavioural model: counts consumed bits of the plan
    logic        m_active = 1'b0, m_done = 1'b0, m_abort = 1'b0, m_hdr_valid = 1'b1;
    int          m_n = 0, m_gap = 0;
    logic [7:0]  m_flen_out = '0;
    logic [28:0] m_id = '0;
    logic        m_ide = 1'b0, m_rtr = 1'b0;
    logic [3:0]  m_dlc = '0;

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0; m_done = 0; m_abort = 0; m_hdr_valid = 1;
                m_n = 0; m_gap = 0; m_flen_out = '0;
                m_id = '0; m_ide = 0; m_rtr = 0; m_dlc = '0;
            end else begin
                m_done  = 0;
                m_abort = 0;
                if (!m_active) begin
                    if (sof && !error && !overload) begin
                        m_active = 1; m_n = 1; m_gap = 0;
                        m_flen_out = '0; m_hdr_valid = 0;
                    end
                end else if (error || overload) begin
                    m_active = 0; m_abort = 1;
                end else if (dvalid) begin
                    m_gap = 0;
                    m_n++;
                    if (m_n == plan_dlc_end + 1) begin
                        m_flen_out = 8'(plan_flen);
                        m_id = plan_id; m_ide = plan_ide; m_rtr = plan_rtr; m_dlc = plan_dlc;
                        m_hdr_valid = 1;
                    end
                    if (m_n == plan_flen) m_done = 1;
                    if (m_n == plan_total) m_active = 0;
                end else begin
                    m_gap++;
                    if (m_gap == WD_CLOCKS) begin
                        m_active = 0; m_abort = 1;
                    end
                end
            end
        end
    end

    // ---------------- compare process, mid-cycle
    initial begin : compare
        int exp_bits;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_bits = m_active ? ((m_n < plan_flen) ? m_n : plan_flen) : 0;
                check("field", 32'(field), m_active ? 32'(plan_field[m_n]) : 32'd0);
                check("sample_en", 32'(sample_en), 32'(m_active));
                check("frame_bits", 32'(frame_bits), 32'(exp_bits));
                check("crc_en", 32'(crc_en), 32'(m_active && (m_n < plan_crc_start)));
                check("length_valid", 32'(length_valid), 32'(m_active && (m_n > plan_dlc_end)));
                check("frame_length_bits", 32'(frame_length_bits), 32'(m_flen_out));
                check("frame_done", 32'(frame_done), 32'(m_done));
                check("frame_abort", 32'(frame_abort), 32'(m_abort));
                if (m_hdr_valid) begin
                    check("id", 32'(id), 32'(m_id));
                    check("ide", 32'(ide), 32'(m_ide));
                    check("rtr", 32'(rtr), 32'(m_rtr));
                    check("dlc", 32'(dlc), 32'(m_dlc));
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame; can inject an abort, stop bits (watchdog) or reset at a bit index.
    task automatic send_frame(input logic ext, input logic r, input logic [28:0] ident, input logic [3:0] d,
                              input int err_at, input logic use_ovl, input int stall_at, input int rst_at,
                              input logic noise, output int done_at, output logic saw_data);
        build_plan(ext, r, ident, d);
        done_at  = -1;
        saw_data = 1'b0;
        for (int k = 0; k < plan_total; k++) begin
            if (k == stall_at) begin
                int waited;
                waited = 0;
                while (waited < 300 && !frame_abort) begin
                    @(posedge clk);
                    #1;
                    waited++;
                end
                check("watchdog_latency", 32'(waited), 32'(WD_CLOCKS));
                break;
            end
            if (k == plan_crc_start) check("crc_en_at_crc", 32'(crc_en), 32'd0);
            din    = plan_bits[k];
            dvalid = 1'b1;
            sof    = (k == 0) || (noise && ($urandom_range(0, 15) == 0));
            if (k == err_at) begin
                if (use_ovl) overload = 1'b1;
                else error = 1'b1;
            end
            @(posedge clk);
            #1;
            dvalid = 1'b0; sof = 1'b0; error = 1'b0; overload = 1'b0;
            if (field == 4'd9) saw_data = 1'b1;
            if (frame_done) done_at = k + 1;
            if (k == err_at) break;
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_field", 32'(field), 32'd0);
                check("rst_frame_bits", 32'(frame_bits), 32'd0);
                check("rst_sample_en", 32'(sample_en), 32'd0);
                check("rst_crc_en", 32'(crc_en), 32'd0);
                check("rst_length_valid", 32'(length_valid), 32'd0);
                check("rst_frame_length", 32'(frame_length_bits), 32'd0);
                check("rst_id", 32'(id), 32'd0);
                check("rst_ide_rtr_dlc", 32'({ide, rtr, dlc}), 32'd0);
                check("rst_no_abort", 32'(frame_abort), 32'd0);
                idle_cycles(2);
                rst_n = 1'b1;
                break;
            end
            if (k + 1 != stall_at) idle_cycles($urandom_range(0, 3));
        end
        $display("frame ext=%0d rtr=%0d id=%08h dlc=%0d planned_len=%0d done_at=%0d", ext, r, plan_id, d,
                 plan_flen, done_at);
    endtask

    initial begin : stim
        int   done_at;
        logic saw_data;
        logic ext, r;
        int   err_at;

        idle_cycles(3);
        check("reset_field", 32'(field), 32'd0);
        check("reset_frame_bits", 32'(frame_bits), 32'd0);
        check("reset_id", 32'(id), 32'd0);
        check("reset_sample_en", 32'(sample_en), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // SOF together with error while idle is dropped
        sof = 1'b1; dvalid = 1'b1; error = 1'b1;
        @(posedge clk);
        #1;
        sof = 1'b0; dvalid = 1'b0; error = 1'b0;
        check("sof_err_field", 32'(field), 32'd0);
        check("sof_err_frame_bits", 32'(frame_bits), 32'd0);
        idle_cycles(2);

        // Standard data frame, ID 0x123, DLC 2
        send_frame(1'b0, 1'b0, {11'h123, 18'd0}, 4'd2, -1, 1'b0, -1, -1, 1'b0, done_at, saw_data);
        check("std_plan_len", 32'(plan_flen), 32'd60);
        check("std_len", 32'(frame_length_bits), 32'd60);
        check("std_id_a", 32'(id[28:18]), 32'h123);
        check("std_done_at", 32'(done_at), 32'd60);
        idle_cycles(3);

        // Extended remote frame, DLC 4
        send_frame(1'b1, 1'b1, 29'h1ABCDE12, 4'd4, -1, 1'b0, -1, -1, 1'b0, done_at, saw_data);
        check("ext_len", 32'(frame_length_bits), 32'd64);
        check("ext_id", 32'(id), 32'h1ABCDE12);
        check("ext_ide_rtr", 32'({ide, rtr}), 32'd3);
        check("ext_no_data", 32'(saw_data), 32'd0);
        check("ext_done_at", 32'(done_at), 32'd64);
        idle_cycles(3);

        // Standard data frame, DLC 15 -> 8 bytes
        send_frame(1'b0, 1'b0, 29'h0ABCDEF0, 4'd15, -1, 1'b0, -1, -1, 1'b0, done_at, saw_data);
        check("dlc15_len", 32'(frame_length_bits), 32'd108);
        check("dlc15_dlc", 32'(dlc), 32'd15);
        check("dlc15_done_at", 32'(done_at), 32'd108);
        idle_cycles(3);

        // Error on the 5th data bit (data starts at bit index 19 in a standard frame)
        send_frame(1'b0, 1'b0, 29'h12345678, 4'd8, 23, 1'b0, -1, -1, 1'b0, done_at, saw_data);
        check("err_abort", 32'(frame_abort), 32'd1);
        check("err_sample_en", 32'(sample_en), 32'd0);
        check("err_field", 32'(field), 32'd0);
        idle_cycles(2);
        send_frame(1'b0, 1'b0, 29'h05550000, 4'd1, -1, 1'b0, -1, -1, 1'b0, done_at, saw_data);
        check("after_err_done_at", 32'(done_at), 32'd52);
        idle_cycles(2);

        // Bits stop mid-CRC (DLC 1: CRC starts at bit index 27)
        send_frame(1'b0, 1'b0, 29'h1F000000, 4'd1, -1, 1'b0, 32, -1, 1'b0, done_at, saw_data);
        idle_cycles(2);

        // Reset mid-DATA
        send_frame(1'b0, 1'b0, 29'h03300000, 4'd4, -1, 1'b0, -1, 25, 1'b0, done_at, saw_data);
        idle_cycles(2);

        // Randomized frames with occasional aborts and stray SOFs
        for (int f = 0; f < 30; f++) begin
            ext    = 1'($urandom_range(0, 1));
            r      = ($urandom_range(0, 3) == 0);
            err_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 70)) : -1;
            send_frame(ext, r, 29'($urandom), 4'($urandom_range(0, 15)), err_at, 1'($urandom_range(0, 1)),
                       -1, -1, 1'b1, done_at, saw_data);
            if ($urandom_range(0, 3) == 0) begin
                error = 1'b1;  // ignored while idle
                idle_cycles(1);
                error = 1'b0;
            end
            idle_cycles($urandom_range(1, 4));
        end

        idle_cycles(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
